// File: rtl/direction_detector_pkg.sv
// Shared types and helpers for the direction detector.
//   dir_t          : reported direction (NONE/LEFT/CENTRE/RIGHT)
//   det_state_t    : pixel-stream alignment state
//   DEF_IMAGE_*    : default frame geometry
//   red_of/green_of/blue_of : RGB444 field extraction {R[11:8],G[7:4],B[3:0]}
package detect_direction_pkg;

  typedef enum logic [1:0] {
    DIR_NONE   = 2'd0,
    DIR_LEFT   = 2'd1,
    DIR_CENTRE = 2'd2,
    DIR_RIGHT  = 2'd3
  } dir_t;

  typedef enum logic [0:0] {
    StAlign = 1'b0,
    StAccum = 1'b1
  } det_state_t;

  localparam int unsigned DEF_IMAGE_WIDTH  = 320;
  localparam int unsigned DEF_IMAGE_HEIGHT = 240;
  localparam int unsigned RGB444_BITS      = 12;

  function automatic logic [3:0] red_of(input logic [RGB444_BITS-1:0] px);
    return px[11:8];
  endfunction

  function automatic logic [3:0] green_of(input logic [RGB444_BITS-1:0] px);
    return px[7:4];
  endfunction

  function automatic logic [3:0] blue_of(input logic [RGB444_BITS-1:0] px);
    return px[3:0];
  endfunction

endpackage

// File: rtl/direction_detector_if.sv
// Pixel-stream / result bundle between the frame-read side and the direction detector.
//   resend       : frame restart (also drives the address generator)
//   rddata       : BRAM read data, one RGB444 pixel per cycle
//   direction    : dir_t result of the last completed frame
//   dir_valid    : one-cycle pulse per completed frame
//   target_count : target pixel count of the last completed frame
// master = frame source / result consumer, slave = detector.
interface direction_detector_if #(
  parameter int unsigned PIXEL_BITS = 12,
  parameter int unsigned CNT_W      = 17
);
  import detect_direction_pkg::*;

  logic                  resend;
  logic [PIXEL_BITS-1:0] rddata;
  dir_t                  direction;
  logic                  dir_valid;
  logic [CNT_W-1:0]      target_count;

  modport master (
    output resend,
    output rddata,
    input  direction,
    input  dir_valid,
    input  target_count
  );

  modport slave (
    input  resend,
    input  rddata,
    output direction,
    output dir_valid,
    output target_count
  );

endinterface

// File: rtl/direction_detector_classifier.sv
// Combinational target test on one RGB444 pixel.
//   pixel     : RGB444 word
//   is_target : R >= RED_MIN and G <= GB_MAX and B <= GB_MAX
module target_pixel_classifier
  import detect_direction_pkg::*;
#(
  parameter int unsigned RED_MIN = 10,
  parameter int unsigned GB_MAX  = 5
) (
  input  logic [RGB444_BITS-1:0] pixel,
  output logic                   is_target
);

  localparam logic [3:0] RED_MIN_C = 4'(RED_MIN);
  localparam logic [3:0] GB_MAX_C  = 4'(GB_MAX);

  always_comb begin
    is_target = (red_of(pixel) >= RED_MIN_C) &&
                (green_of(pixel) <= GB_MAX_C) &&
                (blue_of(pixel) <= GB_MAX_C);
  end

endmodule

// File: rtl/direction_detector.sv
// Classifies the raster-order pixel stream and reports, once per frame, whether the
// red target sits LEFT, CENTRE or RIGHT (or NONE if too few target pixels).
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : resend/rddata in; direction/dir_valid/target_count out
// Optional feature: define DIR_HYSTERESIS_EN to only change direction when two consecutive
// frames agree on the raw decision.
// Pipeline: last pixel sampled at edge S -> snapshot (S) -> decision (S+1) -> outputs (S+2).
module direction_detector
  import detect_direction_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned PIXEL_BITS   = RGB444_BITS,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RED_MIN      = 10,
  parameter int unsigned GB_MAX       = 5,
  parameter int unsigned CENTRE_BAND  = 32,
  parameter int unsigned MIN_PIXELS   = 64
) (
  input logic                 clk,
  input logic                 reset_n,
  direction_detector_if.slave bus
);

  localparam int unsigned NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CNT_W      = $clog2(NUM_PIXELS + 1);
  localparam int unsigned COL_W      = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W      = $clog2(IMAGE_HEIGHT);
  localparam int unsigned PROD_W     = CNT_W + COL_W;
  // Full-frame column sum is at most N*W/2 < 2^(PROD_W-1), so one bit less than the products.
  localparam int unsigned SUM_W      = PROD_W - 1;
  localparam int unsigned LAT_W      = $clog2(READ_LATENCY + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  // Band limits assume CENTRE_BAND < IMAGE_WIDTH/2.
  localparam logic [COL_W-1:0] BAND_LO  = COL_W'(IMAGE_WIDTH / 2 - CENTRE_BAND);
  localparam logic [COL_W-1:0] BAND_HI  = COL_W'(IMAGE_WIDTH / 2 + CENTRE_BAND);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_PIXELS);

  // Stream / accumulation state
  det_state_t        state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  snap_cnt_q;
  logic [SUM_W-1:0]  snap_sum_q;
  logic              snap_vld_q;

  // Decision and output stages
  dir_t              raw_dir;
  logic [PROD_W-1:0] bound_lo, bound_hi;
  dir_t              dec_dir_q;
  logic [CNT_W-1:0]  dec_cnt_q;
  logic              dec_vld_q;
  dir_t              direction_q;
  logic              dir_valid_q;
  logic [CNT_W-1:0]  target_count_q;
`ifdef DIR_HYSTERESIS_EN
  dir_t              prev_raw_q;
`endif

  logic [PIXEL_BITS-1:0] pixel;
  logic                  is_target;
  logic                  last_pixel;

  assign pixel = bus.rddata;

  target_pixel_classifier #(
    .RED_MIN (RED_MIN),
    .GB_MAX  (GB_MAX)
  ) u_classifier (
    .pixel     (pixel[RGB444_BITS-1:0]),
    .is_target (is_target)
  );

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(is_target);
    sum_d      = sum_q + (is_target ? SUM_W'(col_q) : '0);
    last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StAlign;
      lat_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      snap_cnt_q <= '0;
      snap_sum_q <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      snap_vld_q <= 1'b0;
      unique case (state_q)
        StAlign: begin
          col_q <= '0;
          row_q <= '0;
          cnt_q <= '0;
          sum_q <= '0;
          if (bus.resend) begin
            lat_q <= '0;
          end else if (lat_q == LAT_LAST) begin
            lat_q   <= '0;
            state_q <= StAccum;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StAccum: begin
          if (bus.resend) begin
            // Partial frame is dropped; ALIGN clears the accumulators.
            lat_q   <= '0;
            state_q <= StAlign;
          end else if (last_pixel) begin
            // Snapshot includes this pixel; next frame starts accumulating on the next edge.
            snap_cnt_q <= cnt_d;
            snap_sum_q <= sum_d;
            snap_vld_q <= 1'b1;
            cnt_q      <= '0;
            sum_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
          end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= StAlign;
      endcase
    end
  end

  // Mean column compared against band limits without division: sum vs cnt*limit.
  always_comb begin
    bound_lo = {{COL_W{1'b0}}, snap_cnt_q} * {{CNT_W{1'b0}}, BAND_LO};
    bound_hi = {{COL_W{1'b0}}, snap_cnt_q} * {{CNT_W{1'b0}}, BAND_HI};
    raw_dir  = DIR_CENTRE;
    if (snap_cnt_q < CNT_MIN) begin
      raw_dir = DIR_NONE;
    end else if ({1'b0, snap_sum_q} < bound_lo) begin
      raw_dir = DIR_LEFT;
    end else if ({1'b0, snap_sum_q} > bound_hi) begin
      raw_dir = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_dir_q      <= DIR_NONE;
      dec_cnt_q      <= '0;
      dec_vld_q      <= 1'b0;
      direction_q    <= DIR_NONE;
      dir_valid_q    <= 1'b0;
      target_count_q <= '0;
`ifdef DIR_HYSTERESIS_EN
      prev_raw_q     <= DIR_NONE;
`endif
    end else begin
      dec_vld_q <= snap_vld_q;
      if (snap_vld_q) begin
        dec_dir_q <= raw_dir;
        dec_cnt_q <= snap_cnt_q;
      end
      dir_valid_q <= dec_vld_q;
      if (dec_vld_q) begin
        target_count_q <= dec_cnt_q;
`ifdef DIR_HYSTERESIS_EN
        prev_raw_q <= dec_dir_q;
        if (dec_dir_q == prev_raw_q) begin
          direction_q <= dec_dir_q;
        end
`else
        direction_q <= dec_dir_q;
`endif
      end
    end
  end

  assign bus.direction    = direction_q;
  assign bus.dir_valid    = dir_valid_q;
  assign bus.target_count = target_count_q;

endmodule

// File: tb/tb_direction_detector.sv
// Scoreboard bench for direction_detector on a reduced 40x6 frame.
module tb_direction_detector;

  localparam int W       = 40;
  localparam int H       = 6;
  localparam int N       = W * H;
  localparam int LAT     = 2;
  localparam int RED_MIN = 10;
  localparam int GB_MAX  = 5;
  localparam int CB      = 5;
  localparam int MIN_PX  = 8;
  localparam int CNT_W   = $clog2(N + 1);

  typedef struct {
    int dir;
    int cnt;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [11:0] frame_px [N];
`ifdef DIR_HYSTERESIS_EN
  int hist_prev = 0;
  int hist_shown = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  direction_detector_if #(.PIXEL_BITS(12), .CNT_W(CNT_W)) bus ();

  direction_detector #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PIXEL_BITS   (12),
    .READ_LATENCY (LAT),
    .RED_MIN      (RED_MIN),
    .GB_MAX       (GB_MAX),
    .CENTRE_BAND  (CB),
    .MIN_PIXELS   (MIN_PX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  function automatic bit is_tgt(input logic [11:0] p);
    return int'(p[11:8]) >= RED_MIN && int'(p[7:4]) <= GB_MAX && int'(p[3:0]) <= GB_MAX;
  endfunction

  function automatic logic [11:0] rand_tgt();
    logic [3:0] r, g, b;
    r = 4'(RED_MIN + int'($urandom_range(15 - RED_MIN)));
    g = 4'($urandom_range(GB_MAX));
    b = 4'($urandom_range(GB_MAX));
    return {r, g, b};
  endfunction

  function automatic logic [11:0] rand_non();
    logic [11:0] p;
    do p = 12'($urandom); while (is_tgt(p));
    return p;
  endfunction

  // Reference: mean column vs band, expressed as sum against cnt*limit.
  function automatic int raw_decision(input int cnt, input longint sum);
    if (cnt < MIN_PX) return 0;
    if (sum < longint'(cnt) * (W / 2 - CB)) return 1;
    if (sum > longint'(cnt) * (W / 2 + CB)) return 3;
    return 2;
  endfunction

  task automatic put(input int row, input int col);
    frame_px[row * W + col] = rand_tgt();
  endtask

  task automatic build_frame(input int kind);
    int c0, c1;
    c0 = int'($urandom_range(W - 1));
    c1 = c0 + int'($urandom_range(12));
    if (c1 > W - 1) c1 = W - 1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = i % W;
      case (kind)
        0: frame_px[i] = 12'h000;
        1: frame_px[i] = (c <= 9) ? 12'hF00 : 12'h000;
        2: frame_px[i] = (c >= 17 && c <= 22) ? 12'hF00 : 12'h000;
        3: frame_px[i] = (c >= 30) ? 12'hF00 : 12'h000;
        4: frame_px[i] = 12'($urandom);
        5: frame_px[i] = (c >= c0 && c <= c1 && $urandom_range(3) != 0) ? rand_tgt() : rand_non();
        12: begin
          case ($urandom_range(3))
            0: frame_px[i] = {4'(RED_MIN), 4'(GB_MAX), 4'(GB_MAX)};
            1: frame_px[i] = {4'(RED_MIN - 1), 4'h0, 4'h0};
            2: frame_px[i] = {4'hF, 4'(GB_MAX + 1), 4'h0};
            default: frame_px[i] = {4'hF, 4'h0, 4'(GB_MAX + 1)};
          endcase
        end
        default: frame_px[i] = rand_non();
      endcase
    end
    case (kind)
      6: for (int k = 0; k < MIN_PX - 1; k++) frame_px[$urandom_range(N - 1)] = rand_tgt();
      7: for (int r = 0; r < 4; r++) begin put(r, 0); put(r, 1); end
      8: for (int r = 0; r < 4; r++) begin put(r, 14); put(r, 16); end
      9: begin
        for (int r = 0; r < 4; r++) put(r, 14);
        for (int r = 0; r < 3; r++) put(r, 16);
        put(3, 15);
      end
      10: for (int r = 0; r < 4; r++) begin put(r, 24); put(r, 26); end
      11: begin
        for (int r = 0; r < 4; r++) put(r, 24);
        for (int r = 0; r < 3; r++) put(r, 26);
        put(3, 27);
      end
      default: ;
    endcase
  endtask

  task automatic step_junk();
    bus.rddata = 12'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic align(output int drop);
    bus.resend = 1'b0;
    drop = cyc;
    repeat (LAT) step_junk();
  endtask

  task automatic drive_partial(input int n);
    build_frame(5);
    for (int i = 0; i < n; i++) begin
      bus.rddata = frame_px[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int kind, input bit from_drop, input int drop);
    int     cnt;
    longint sum;
    int     raw;
    exp_t   e;
    build_frame(kind);
    cnt = 0;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (is_tgt(frame_px[i])) begin
        cnt++;
        sum += longint'(i % W);
      end
    end
    raw = raw_decision(cnt, sum);
`ifdef DIR_HYSTERESIS_EN
    if (raw == hist_prev) hist_shown = raw;
    hist_prev = raw;
    e.dir = hist_shown;
`else
    e.dir = raw;
`endif
    e.cnt = cnt;
    for (int i = 0; i < N; i++) begin
      bus.rddata = frame_px[i];
      if (i == N - 1) begin
        e.cyc = from_drop ? drop + LAT + N + 2 : cyc + 3;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_direction"}, int'(bus.direction), 0);
    check({tag, "_dir_valid"}, int'(bus.dir_valid), 0);
    check({tag, "_target_count"}, int'(bus.target_count), 0);
  endtask

  // Monitor: every pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (reset_n && bus.dir_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("direction", int'(bus.direction), mon_e.dir);
        check("target_count", int'(bus.target_count), mon_e.cnt);
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop;
    bus.resend = 1'b1;
    bus.rddata = '0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset_n = 1'b1;
    step_junk();

    align(drop);
    drive_frame(0, 1'b1, drop);
    for (int k = 1; k <= 3; k++) drive_frame(k, 1'b0, 0);
    for (int k = 6; k <= 12; k++) drive_frame(k, 1'b0, 0);
    repeat (10) drive_frame(4 + int'($urandom_range(1)), 1'b0, 0);

    // Mid-frame resend: partial frame must vanish.
    drive_partial(100);
    bus.resend = 1'b1;
    repeat (2) step_junk();
    align(drop);
    drive_frame(5, 1'b1, drop);

    // Resend right after a last pixel: that frame's decision still reports.
    drive_frame(1, 1'b0, 0);
    bus.resend = 1'b1;
    step_junk();
    align(drop);
    drive_frame(3, 1'b1, drop);

    // Reset in the middle of accumulation.
    drive_partial(100);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midreset");
`ifdef DIR_HYSTERESIS_EN
    hist_prev  = 0;
    hist_shown = 0;
`endif
    reset_n = 1'b1;
    align(drop);
    drive_frame(2, 1'b1, drop);
    drive_frame(4, 1'b0, 0);

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
